// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath: headings,
// controller states, coordinate widths and the start-of-game body layout.
package snake_pkg;

  localparam int X_W            = 8;
  localparam int Y_W            = 7;
  localparam int GRID_X_DEFAULT = 80;
  localparam int GRID_Y_DEFAULT = 60;
  localparam int HOME_X         = 40;
  localparam int HOME_Y         = 30;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Opposite headings differ only in the upper encoding bit.
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  // Start layout: a horizontal row ending at the home cell, head on the right.
  function automatic logic [X_W-1:0] home_seg_x(input int idx, input int init_len);
    return (idx < init_len) ? X_W'(HOME_X - idx) : '0;
  endfunction

  function automatic logic [Y_W-1:0] home_seg_y(input int idx, input int init_len);
    return (idx < init_len) ? Y_W'(HOME_Y) : '0;
  endfunction

endpackage

// File: rtl/snake_move_timer.sv
// Move-rate divider: counts enabled cycles 0..TICK_DIV-1 and flags the last
// one as the cycle in which the snake steps. Held at zero while disabled so
// each new game starts a full period before its first move.
module snake_move_timer #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic move_stb
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and the move strobe for the current cycle.
  always_comb begin
    cnt_d    = '0;
    move_stb = 1'b0;
    if (en) begin
      move_stb = (cnt_q == LAST);
      cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: position, heading, growth, collision, score and the
// per-cell hit queries used by the colour stage.
// Build option: define SNAKE_WALL_WRAP_EN to make the grid edges wrap around
// instead of ending the game.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 5000000,
  parameter int GRID_X   = GRID_X_DEFAULT,
  parameter int GRID_Y   = GRID_Y_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [1:0] DIR,
  input  logic [7:0] TARGET_ADDR_H,
  input  logic [6:0] TARGET_ADDR_V,
  input  logic [7:0] QUERY_X,
  input  logic [6:0] QUERY_Y,
  output logic       TARGET_REACHED,
  output logic       SNAKE_HIT,
  output logic       HEAD_HIT,
  output logic       GAME_OVER,
  output logic [7:0] SCORE,
  output logic [1:0] STATE
);

  localparam int LEN_W = 7;
`ifdef SNAKE_WALL_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  dir_e             heading_q, heading_d;
  dir_e             next_heading_q, next_heading_d;
  logic [7:0]       score_q, score_d;
  logic             reached_q, reached_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [X_W-1:0]   seg_x_d [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_d [MAX_LEN];

  logic           move_stb;
  logic           play_en;
  dir_e           dir_req;
  dir_e           heading_sel;
  logic [X_W-1:0] nh_x;
  logic [Y_W-1:0] nh_y;
  logic           edge_hit;
  logic           wall_hit;
  logic           self_hit;
  logic           target_hit;

  assign play_en = (state_q == ST_PLAY);

  snake_move_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_move_timer (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .en      (play_en),
    .move_stb(move_stb)
  );

  // Filter reverse requests, then step the head and classify the landing cell.
  always_comb begin
    dir_req     = dir_e'(DIR);
    heading_sel = (dir_req == reverse_dir(heading_q)) ? next_heading_q : dir_req;
    nh_x        = seg_x_q[0];
    nh_y        = seg_y_q[0];
    edge_hit    = 1'b0;
    case (heading_sel)
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin
          edge_hit = 1'b1;
          nh_y     = Y_W'(GRID_Y - 1);
        end else begin
          nh_y = seg_y_q[0] - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (seg_x_q[0] == X_W'(GRID_X - 1)) begin
          edge_hit = 1'b1;
          nh_x     = '0;
        end else begin
          nh_x = seg_x_q[0] + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (seg_y_q[0] == Y_W'(GRID_Y - 1)) begin
          edge_hit = 1'b1;
          nh_y     = '0;
        end else begin
          nh_y = seg_y_q[0] + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin
          edge_hit = 1'b1;
          nh_x     = X_W'(GRID_X - 1);
        end else begin
          nh_x = seg_x_q[0] - 1'b1;
        end
      end
    endcase
    wall_hit = edge_hit & ~WRAP_EN;
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i + 2) <= int'(len_q) && seg_x_q[i] == nh_x && seg_y_q[i] == nh_y) begin
        self_hit = 1'b1;
      end
    end
    target_hit = (nh_x == TARGET_ADDR_H) && (nh_y == TARGET_ADDR_V);
  end

  // Game FSM plus body shift, growth and scoring.
  always_comb begin
    state_d        = state_q;
    heading_d      = heading_q;
    next_heading_d = next_heading_q;
    score_d        = score_q;
    reached_d      = 1'b0;
    len_d          = len_q;
    seg_x_d        = seg_x_q;
    seg_y_d        = seg_y_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        next_heading_d = heading_sel;
        if (move_stb) begin
          heading_d = heading_sel;
          if (wall_hit || self_hit) begin
            state_d = ST_DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nh_x;
            seg_y_d[0] = nh_y;
            if (target_hit) begin
              reached_d = 1'b1;
              if (len_q < LEN_W'(MAX_LEN)) len_d = len_q + 1'b1;
              if (score_q != 8'hFF) score_d = score_q + 1'b1;
            end
          end
        end
      end
      ST_DEAD: begin
        if (START) begin
          state_d        = ST_IDLE;
          heading_d      = DIR_RIGHT;
          next_heading_d = DIR_RIGHT;
          score_d        = '0;
          len_d          = LEN_W'(INIT_LEN);
          for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = home_seg_x(i, INIT_LEN);
            seg_y_d[i] = home_seg_y(i, INIT_LEN);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, body and score registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_IDLE;
      heading_q      <= DIR_RIGHT;
      next_heading_q <= DIR_RIGHT;
      score_q        <= '0;
      reached_q      <= 1'b0;
      len_q          <= LEN_W'(INIT_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= home_seg_x(i, INIT_LEN);
        seg_y_q[i] <= home_seg_y(i, INIT_LEN);
      end
    end else begin
      state_q        <= state_d;
      heading_q      <= heading_d;
      next_heading_q <= next_heading_d;
      score_q        <= score_d;
      reached_q      <= reached_d;
      len_q          <= len_d;
      seg_x_q        <= seg_x_d;
      seg_y_q        <= seg_y_d;
    end
  end

  // Zero-latency cell queries over the live part of the body.
  always_comb begin
    SNAKE_HIT = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_q) && seg_x_q[i] == QUERY_X && seg_y_q[i] == QUERY_Y) begin
        SNAKE_HIT = 1'b1;
      end
    end
    HEAD_HIT = (seg_x_q[0] == QUERY_X) && (seg_y_q[0] == QUERY_Y);
  end

  assign TARGET_REACHED = reached_q;
  assign GAME_OVER      = (state_q == ST_DEAD);
  assign SCORE          = score_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Testbench for snake_body_ctrl: a queue-based model of the snake checked
// against the DUT on every falling clock edge, directed scenarios pinned with
// literal expectations, then a randomized play phase.
module tb_snake_body_ctrl;

  localparam int TICK    = 4;
  localparam int MAXL    = 32;
  localparam int GX      = 80;
  localparam int GY      = 60;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic [1:0] DIR;
  logic [7:0] TARGET_ADDR_H;
  logic [6:0] TARGET_ADDR_V;
  logic [7:0] QUERY_X;
  logic [6:0] QUERY_Y;
  logic       TARGET_REACHED;
  logic       SNAKE_HIT;
  logic       HEAD_HIT;
  logic       GAME_OVER;
  logic [7:0] SCORE;
  logic [1:0] STATE;

  snake_body_ctrl #(
    .MAX_LEN (MAXL),
    .INIT_LEN(4),
    .TICK_DIV(TICK),
    .GRID_X  (GX),
    .GRID_Y  (GY)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .START         (START),
    .DIR           (DIR),
    .TARGET_ADDR_H (TARGET_ADDR_H),
    .TARGET_ADDR_V (TARGET_ADDR_V),
    .QUERY_X       (QUERY_X),
    .QUERY_Y       (QUERY_Y),
    .TARGET_REACHED(TARGET_REACHED),
    .SNAKE_HIT     (SNAKE_HIT),
    .HEAD_HIT      (HEAD_HIT),
    .GAME_OVER     (GAME_OVER),
    .SCORE         (SCORE),
    .STATE         (STATE)
  );

  // 20 ns clock.
  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: body as a queue of cells, head at the front.
  typedef struct {int x; int y;} cell_t;
  cell_t m_body[$];
  int    m_state;
  int    m_score;
  int    m_cnt;
  int    m_heading;
  int    m_next;
  int    m_reached;

  function automatic void model_init();
    m_body.delete();
    for (int i = 0; i < 4; i++) m_body.push_back('{x: 40 - i, y: 30});
    m_state   = 0;
    m_score   = 0;
    m_cnt     = 0;
    m_heading = 1;
    m_next    = 1;
    m_reached = 0;
  endfunction

  function automatic void model_step(input int dir, input bit start, input int tx, input int ty);
    int  cand;
    int  nx;
    int  ny;
    bit  dead;
    int  pulse;
    pulse = 0;
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        cand   = (dir == (m_heading + 2) % 4) ? m_next : dir;
        m_next = cand;
        if (m_cnt == TICK - 1) begin
          m_heading = cand;
          nx   = m_body[0].x + ((cand == 1) ? 1 : 0) - ((cand == 3) ? 1 : 0);
          ny   = m_body[0].y + ((cand == 2) ? 1 : 0) - ((cand == 0) ? 1 : 0);
          dead = 1'b0;
`ifdef SNAKE_WALL_WRAP_EN
          nx = (nx + GX) % GX;
          ny = (ny + GY) % GY;
`else
          if (nx < 0 || nx >= GX || ny < 0 || ny >= GY) dead = 1'b1;
`endif
          for (int i = 1; i <= m_body.size() - 2; i++)
            if (m_body[i].x == nx && m_body[i].y == ny) dead = 1'b1;
          if (dead) begin
            m_state = 2;
          end else begin
            m_body.push_front('{x: nx, y: ny});
            if (nx == tx && ny == ty) begin
              pulse = 1;
              if (m_score < 255) m_score++;
            end else begin
              void'(m_body.pop_back());
            end
            if (m_body.size() > MAXL) void'(m_body.pop_back());
          end
        end
        m_cnt = (m_cnt + 1) % TICK;
      end
      2: if (start) model_init();
      default: ;
    endcase
    m_reached = pulse;
  endfunction

  // Advance the model with the inputs seen at each rising edge.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) model_init();
    else model_step(int'(DIR), START, int'(TARGET_ADDR_H), int'(TARGET_ADDR_V));
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    int es;
    int eh;
    if (check_en) begin
      es = 0;
      foreach (m_body[i])
        if (m_body[i].x == int'(QUERY_X) && m_body[i].y == int'(QUERY_Y)) es = 1;
      eh = (m_body[0].x == int'(QUERY_X) && m_body[0].y == int'(QUERY_Y)) ? 1 : 0;
      check_output("state", int'(STATE), m_state);
      check_output("score", int'(SCORE), m_score);
      check_output("game_over", int'(GAME_OVER), (m_state == 2) ? 1 : 0);
      check_output("target_reached", int'(TARGET_REACHED), m_reached);
      check_output("snake_hit", int'(SNAKE_HIT), es);
      check_output("head_hit", int'(HEAD_HIT), eh);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input bit start, input int dir, input int tx, input int ty);
    START         = start;
    DIR           = 2'(dir);
    TARGET_ADDR_H = 8'(tx);
    TARGET_ADDR_V = 7'(ty);
  endtask

  task automatic query_check(input string name, input int x, input int y,
                             input int exp_snake, input int exp_head);
    QUERY_X = 8'(x);
    QUERY_Y = 7'(y);
    #1;
    check_output({name, "_snake"}, int'(SNAKE_HIT), exp_snake);
    check_output({name, "_head"}, int'(HEAD_HIT), exp_head);
  endtask

  initial begin
    int ax;
    int ay;
    int k;
    RESET_N = 1'b1;
    QUERY_X = '0;
    QUERY_Y = '0;
    apply_stimulus(1'b0, 1, 0, 0);
    #2 RESET_N = 1'b0;
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    check_en = 1'b1;

    // Reset layout and outputs.
    check_output("rst_state", int'(STATE), 0);
    check_output("rst_score", int'(SCORE), 0);
    check_output("rst_game_over", int'(GAME_OVER), 0);
    check_output("rst_reached", int'(TARGET_REACHED), 0);
    query_check("rst_q40", 40, 30, 1, 1);
    query_check("rst_q37", 37, 30, 1, 0);
    query_check("rst_q36", 36, 30, 0, 0);

    // Start and first move after four PLAY cycles.
    apply_stimulus(1'b1, 1, 0, 0);
    step(1);
    START = 1'b0;
    check_output("start_state", int'(STATE), 1);
    step(3);
    query_check("pre_move", 40, 30, 1, 1);
    step(1);
    query_check("mv1_head", 41, 30, 1, 1);
    query_check("mv1_tail", 38, 30, 1, 0);
    query_check("mv1_gone", 37, 30, 0, 0);
    check_output("mv1_reached", int'(TARGET_REACHED), 0);
    check_output("model_head_x", m_body[0].x, 41);

    // Eat a target on the second move.
    apply_stimulus(1'b0, 1, 42, 30);
    step(4);
    check_output("eat_reached", int'(TARGET_REACHED), 1);
    check_output("eat_score", int'(SCORE), 1);
    query_check("eat_head", 42, 30, 1, 1);
    query_check("eat_tail", 38, 30, 1, 0);
    check_output("model_len", m_body.size(), 5);
    step(1);
    check_output("eat_pulse_end", int'(TARGET_REACHED), 0);

    // Reverse request is ignored, then a real turn up.
    apply_stimulus(1'b0, 3, 0, 59);
    step(3);
    query_check("rev_head", 43, 30, 1, 1);
    DIR = 2'd0;
    step(4);
    query_check("up_head", 43, 29, 1, 1);

    // Right, down, then left into its own body.
    DIR = 2'd1;
    step(4);
    query_check("r_head", 44, 29, 1, 1);
    DIR = 2'd2;
    step(4);
    query_check("d_head", 44, 30, 1, 1);
    DIR = 2'd3;
    step(4);
    check_output("self_state", int'(STATE), 2);
    check_output("self_game_over", int'(GAME_OVER), 1);
    step(6);
    query_check("frozen_head", 44, 30, 1, 1);
    query_check("frozen_body", 43, 29, 1, 0);

    // Restart: DEAD -> IDLE with the layout restored, then PLAY.
    apply_stimulus(1'b1, 1, 0, 0);
    step(1);
    START = 1'b0;
    check_output("reinit_state", int'(STATE), 0);
    check_output("reinit_score", int'(SCORE), 0);
    query_check("reinit_head", 40, 30, 1, 1);
    query_check("reinit_old", 44, 30, 0, 0);
    START = 1'b1;
    step(1);
    START = 1'b0;
    check_output("replay_state", int'(STATE), 1);

    // Run to the right edge and take one more step.
    step(4 * 39);
    query_check("edge_head", 79, 30, 1, 1);
    step(4);
`ifdef SNAKE_WALL_WRAP_EN
    check_output("wrap_state", int'(STATE), 1);
    query_check("wrap_head", 0, 30, 1, 1);
`else
    check_output("wall_state", int'(STATE), 2);
    check_output("wall_game_over", int'(GAME_OVER), 1);
    query_check("wall_head", 79, 30, 1, 1);
`endif

    // Asynchronous reset in the middle of a move period.
    RESET_N = 1'b0;
    step(1);
    RESET_N = 1'b1;
    apply_stimulus(1'b1, 1, 41, 30);
    step(1);
    START = 1'b0;
    step(4);
    check_output("pre_rst_score", int'(SCORE), 1);
    step(1);
    #3 RESET_N = 1'b0;
    #1;
    check_output("arst_state", int'(STATE), 0);
    check_output("arst_score", int'(SCORE), 0);
    check_output("arst_reached", int'(TARGET_REACHED), 0);
    query_check("arst_head", 40, 30, 1, 1);
    query_check("arst_old", 41, 30, 0, 0);
    step(1);
    RESET_N = 1'b1;

    // Randomized play against the model.
    for (int c = 0; c < 4000; c++) begin
      START = ($urandom_range(0, 29) == 0);
      if (m_cnt == 1 && $urandom_range(0, 2) == 0) DIR = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        ax = m_body[0].x + ((m_next == 1) ? 1 : 0) - ((m_next == 3) ? 1 : 0);
        ay = m_body[0].y + ((m_next == 2) ? 1 : 0) - ((m_next == 0) ? 1 : 0);
        if (ax >= 0 && ax < GX && ay >= 0 && ay < GY) begin
          TARGET_ADDR_H = 8'(ax);
          TARGET_ADDR_V = 7'(ay);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        TARGET_ADDR_H = 8'($urandom_range(0, GX - 1));
        TARGET_ADDR_V = 7'($urandom_range(0, GY - 1));
      end
      if ($urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, m_body.size() - 1);
        QUERY_X = 8'(m_body[k].x);
        QUERY_Y = 7'(m_body[k].y);
      end else begin
        QUERY_X = 8'($urandom_range(0, GX - 1));
        QUERY_Y = 7'($urandom_range(0, GY - 1));
      end
      if ($urandom_range(0, 999) == 0) begin
        #3 RESET_N = 1'b0;
        #4 RESET_N = 1'b1;
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
